// File: rtl/chg_txt_fetch.sv
// Change-list fetch sequencer: reads the entry count from change-SRAM word 0, then presents
// each {row, col, real, img} entry to the Y-update stage under a valid/done handshake.
module chg_txt_fetch #(
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned MAX_ENTRIES = 2047
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [79:0]       chg_readData,
  output logic [ADDR_W-1:0] chg_readAddr,
  output logic [15:0]       chg_row,
  output logic [15:0]       chg_col,
  output logic [23:0]       chg_real,
  output logic [23:0]       chg_img,
  output logic              chg_valid,
  input  logic              entry_done,
  output logic [ADDR_W-1:0] entry_index,
  output logic              seq_busy,
  output logic              seq_done
);

  typedef enum logic [2:0] {
    StIdle,
    StCntRd,
    StCntLatch,
    StEntRd,
    StEntLatch,
    StPresent,
    StFinish
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [15:0]       row_q, row_d, col_q, col_d;
  logic [23:0]       real_q, real_d, img_q, img_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] clamped_count;
  logic [ADDR_W-1:0] idx_inc;

  // Clamp before narrowing so an oversized count can never wrap the address range.
  always_comb begin
    if (32'(chg_readData[15:0]) > MAX_ENTRIES) begin
      clamped_count = ADDR_W'(MAX_ENTRIES);
    end else begin
      clamped_count = ADDR_W'(chg_readData[15:0]);
    end
  end

  assign idx_inc = idx_q + ADDR_W'(1);

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    idx_d        = idx_q;
    index_d      = index_q;
    row_d        = row_q;
    col_d        = col_q;
    real_d       = real_q;
    img_d        = img_q;
    valid_d      = valid_q;
    chg_readAddr = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          idx_d   = '0;
          state_d = StCntRd;
        end
      end
      StCntRd: begin
        chg_readAddr = '0;
        state_d      = StCntLatch;
      end
      StCntLatch: begin
        count_d = clamped_count;
        state_d = (clamped_count == '0) ? StFinish : StEntRd;
      end
      StEntRd: begin
        chg_readAddr = idx_inc;
        state_d      = StEntLatch;
      end
      StEntLatch: begin
        row_d   = chg_readData[79:64];
        col_d   = chg_readData[63:48];
        real_d  = chg_readData[47:24];
        img_d   = chg_readData[23:0];
        index_d = idx_q;
        valid_d = 1'b1;
        state_d = StPresent;
      end
      StPresent: begin
        if (entry_done) begin
          valid_d = 1'b0;
          idx_d   = idx_inc;
          state_d = (idx_inc == count_q) ? StFinish : StEntRd;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      count_q <= '0;
      idx_q   <= '0;
      index_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      real_q  <= '0;
      img_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      index_q <= index_d;
      row_q   <= row_d;
      col_q   <= col_d;
      real_q  <= real_d;
      img_q   <= img_d;
      valid_q <= valid_d;
    end
  end

  assign chg_row     = row_q;
  assign chg_col     = col_q;
  assign chg_real    = real_q;
  assign chg_img     = img_q;
  assign chg_valid   = valid_q;
  assign entry_index = index_q;
  assign seq_busy    = (state_q != StIdle);
  assign seq_done    = (state_q == StFinish);

endmodule

// File: tb/tb_chg_txt_fetch.sv
// Directed bench for chg_txt_fetch: a default instance plus a MAX_ENTRIES=4 instance for the
// clamp case, each backed by a small synchronous-read SRAM model.
module tb_chg_txt_fetch;
  localparam int unsigned AW = 11;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset, start1, done1, start2, done2, clr_log;
  logic [79:0]   rd1, rd2;
  logic [AW-1:0] ra1, ra2, idx1, idx2, max1, max2;
  logic [15:0]   row1, col1, row2, col2;
  logic [23:0]   re1, im1, re2, im2;
  logic          v1, v2, busy1, busy2, sd1, sd2;
  logic [79:0]   mem1 [16];
  logic [79:0]   mem2 [16];
  int            pass_cnt = 0;
  int            total = 0;

  chg_txt_fetch #(.ADDR_W(AW)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .chg_readData(rd1), .chg_readAddr(ra1),
    .chg_row(row1), .chg_col(col1), .chg_real(re1), .chg_img(im1), .chg_valid(v1),
    .entry_done(done1), .entry_index(idx1), .seq_busy(busy1), .seq_done(sd1)
  );

  chg_txt_fetch #(.ADDR_W(AW), .MAX_ENTRIES(4)) dut2 (
    .clock(clock), .reset(reset), .start(start2), .chg_readData(rd2), .chg_readAddr(ra2),
    .chg_row(row2), .chg_col(col2), .chg_real(re2), .chg_img(im2), .chg_valid(v2),
    .entry_done(done2), .entry_index(idx2), .seq_busy(busy2), .seq_done(sd2)
  );

  always @(posedge clock) begin
    rd1 <= (ra1 < AW'(16)) ? mem1[ra1[3:0]] : '0;
    rd2 <= (ra2 < AW'(16)) ? mem2[ra2[3:0]] : '0;
  end

  // Highest address driven since the last clear.
  always @(posedge clock) begin
    if (clr_log) begin
      max1 <= '0;
      max2 <= '0;
    end else begin
      if (ra1 > max1) max1 <= ra1;
      if (ra2 > max2) max2 <= ra2;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_valid1(output int n);
    n = 0;
    while (!v1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic check_entry(input string tag, input int i, input logic [79:0] w);
    chk({tag, ".valid"}, v1, 1'b1);
    chk({tag, ".index"}, idx1, AW'(i));
    chk({tag, ".row"}, row1, w[79:64]);
    chk({tag, ".col"}, col1, w[63:48]);
    chk({tag, ".real"}, re1, w[47:24]);
    chk({tag, ".img"}, im1, w[23:0]);
  endtask

  initial begin
    int n, k, pres;
    logic [AW-1:0] last_idx;
    logic [15:0]   last_row;

    reset = 1'b0; start1 = 1'b0; done1 = 1'b0; start2 = 1'b0; done2 = 1'b0; clr_log = 1'b1;
    mem1[0] = 80'd3;
    mem1[1] = {16'd1, 16'd2, 24'h000100, 24'hFFFF00};
    mem1[2] = {16'd5, 16'd5, 24'h123456, 24'hABCDEF};
    mem1[3] = {16'd7, 16'd9, 24'h800000, 24'h7FFFFF};
    for (int i = 4; i < 16; i++) mem1[i] = {16'(i), 16'hEEEE, 24'hDEAD00, 24'h00BEEF};
    mem2[0] = 80'h0000_FFFF;
    for (int i = 1; i < 16; i++) mem2[i] = {16'(i + 100), 16'(i), 24'h0, 24'h1};
    tick();
    tick();
    chk("rst.valid", v1, 1'b0);
    chk("rst.busy", busy1, 1'b0);
    chk("rst.done", sd1, 1'b0);
    chk("rst.addr", ra1, '0);
    chk("rst.index", idx1, '0);
    chk("rst.row", row1, '0);
    reset = 1'b1;
    clr_log = 1'b0;
    tick();

    // Three entries, done two cycles after each valid.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("A.busy", busy1, 1'b1);
    wait_valid1(n);
    chk("A.lat_start", n, 4);
    for (int e = 0; e < 3; e++) begin
      if (e > 0) begin
        wait_valid1(n);
        chk("A.lat_done", n, 2);
      end
      check_entry("A", e, mem1[e + 1]);
      tick();
      chk("A.hold_valid", v1, 1'b1);
      chk("A.hold_real", re1, mem1[e + 1][47:24]);
      done1 = 1'b1;
      tick();
      done1 = 1'b0;
      chk("A.valid_clr", v1, 1'b0);
    end
    chk("A.seq_done", sd1, 1'b1);
    tick();
    chk("A.seq_done_end", sd1, 1'b0);
    chk("A.idle", busy1, 1'b0);
    chk("A.max_addr", max1, AW'(3));

    // Empty list.
    mem1[0] = 80'd0;
    clr_log = 1'b1;
    tick();
    clr_log = 1'b0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    chk("B.done_early", sd1, 1'b0);
    tick();
    chk("B.seq_done", sd1, 1'b1);
    chk("B.no_valid", v1, 1'b0);
    tick();
    chk("B.seq_done_end", sd1, 1'b0);
    chk("B.idle", busy1, 1'b0);
    chk("B.max_addr", max1, '0);
    mem1[0] = 80'd3;

    // Stray done in ENT_RD/ENT_LATCH, start while busy, start+done together in PRESENT.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tick();
    done1 = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    done1 = 1'b0;
    chk("C.valid0", v1, 1'b1);
    chk("C.index0", idx1, '0);
    tick();
    chk("C.hold", v1, 1'b1);
    done1 = 1'b1;
    start1 = 1'b1;
    tick();
    done1 = 1'b0;
    start1 = 1'b0;
    chk("C.valid_clr", v1, 1'b0);
    wait_valid1(n);
    chk("C.lat1", n, 2);
    chk("C.index1", idx1, AW'(1));
    done1 = 1'b1;
    tick();
    done1 = 1'b0;
    wait_valid1(n);
    chk("C.index2", idx1, AW'(2));
    chk("C.col2", col1, 16'd9);
    done1 = 1'b1;
    tick();
    done1 = 1'b0;
    chk("C.seq_done", sd1, 1'b1);
    tick();
    tick();
    chk("C.no_restart", busy1, 1'b0);

    // Reset while presenting entry 1.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    wait_valid1(n);
    done1 = 1'b1;
    tick();
    done1 = 1'b0;
    wait_valid1(n);
    chk("D.index1", idx1, AW'(1));
    #1;
    reset = 1'b0;
    #1;
    chk("D.valid", v1, 1'b0);
    chk("D.busy", busy1, 1'b0);
    chk("D.addr", ra1, '0);
    chk("D.index", idx1, '0);
    chk("D.row", row1, '0);
    tick();
    tick();
    chk("D.no_done", sd1, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    chk("D.wait_start", busy1, 1'b0);
    chk("D.no_done2", sd1, 1'b0);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    wait_valid1(n);
    chk("D.restart_lat", n, 4);
    check_entry("D", 0, mem1[1]);
    done1 = 1'b1;
    k = 0;
    while (!sd1 && k < 40) begin
      tick();
      k++;
    end
    chk("D.finish", sd1, 1'b1);
    tick();

    // entry_done held high throughout.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    wait_valid1(n);
    chk("E.lat_start", n, 4);
    check_entry("E0", 0, mem1[1]);
    for (int e = 1; e < 3; e++) begin
      tick();
      chk("E.gap1", v1, 1'b0);
      tick();
      chk("E.gap2", v1, 1'b0);
      tick();
      chk("E.valid", v1, 1'b1);
      chk("E.index", idx1, AW'(e));
      chk("E.row", row1, mem1[e + 1][79:64]);
    end
    tick();
    chk("E.valid_end", v1, 1'b0);
    chk("E.seq_done", sd1, 1'b1);
    done1 = 1'b0;
    tick();

    // Count 0xFFFF clamped to 4 on the second instance.
    clr_log = 1'b1;
    tick();
    clr_log = 1'b0;
    done2 = 1'b1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    k = 0;
    pres = 0;
    last_idx = '0;
    last_row = '0;
    while (!sd2 && k < 60) begin
      tick();
      k++;
      if (v2) begin
        pres++;
        last_idx = idx2;
        last_row = row2;
      end
    end
    chk("F.seq_done", sd2, 1'b1);
    chk("F.presentations", pres, 4);
    chk("F.last_index", last_idx, AW'(3));
    chk("F.last_row", last_row, 16'd104);
    chk("F.max_addr", max2, AW'(4));
    done2 = 1'b0;
    tick();
    chk("F.idle", busy2, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
